// File: rtl/stack_cpu_pkg.sv
// Shared stack-processor definitions: opcode constants, immediate size and
// the built-in demo program image.
package stack_cpu_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_POP   = 8'h02;
  localparam logic [7:0] OP_PUSH  = 8'h10;
  localparam logic [7:0] OP_PUSH0 = 8'h11;
  localparam logic [7:0] OP_INC   = 8'h20;
  localparam logic [7:0] OP_BR    = 8'h30;
  localparam logic [7:0] OP_SHOW  = 8'hFE;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam int unsigned IMM_BYTES = 4;

  // Demo program: push0, show, inc, push 1, br.
  function automatic logic [7:0] default_image(input int unsigned addr);
    logic [7:0] b;
    b = OP_NOP;
    case (addr)
      0:       b = OP_PUSH0;
      1:       b = OP_SHOW;
      2:       b = OP_INC;
      3:       b = OP_PUSH;
      4:       b = 8'h01;
      8:       b = OP_BR;
      default: b = OP_NOP;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/instruction_memory_if.sv
// Fetch/write bus between the core and the instruction memory.
interface instruction_memory_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [31:0]       index;
  logic [7:0]        instruction;
  logic [31:0]       constant;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output index, wr_en, wr_addr, wr_data,
    input  instruction, constant
  );

  modport slave (
    input  index, wr_en, wr_addr, wr_data,
    output instruction, constant
  );
endinterface

// File: rtl/instruction_memory_imm_assemble.sv
// Gathers the four bytes following the opcode into a little-endian
// immediate, zeroing any byte whose address falls past the end of memory.
module imm_assemble
  import stack_cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic [31:0] index,
  input  logic [7:0]  mem [DEPTH],
  output logic [31:0] constant
);

  // 33-bit sums keep indexes near 2^32-1 from wrapping into low memory.
  for (genvar k = 0; k < IMM_BYTES; k++) begin : g_byte
    logic [32:0] addr;
    logic        in_range;
    assign addr     = {1'b0, index} + 33'(k + 1);
    assign in_range = addr < 33'(DEPTH);
    assign constant[8*k +: 8] = in_range ? mem[addr[ADDR_W-1:0]] : 8'h00;
  end

endmodule

// File: rtl/instruction_memory.sv
// Byte-addressed program store with combinational opcode/immediate reads.
// Write port enabled by defining INSTRUCTION_MEMORY_WRITE_EN; otherwise a ROM.
module instruction_memory
  import stack_cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst,
  instruction_memory_if.slave bus
);

  logic [7:0] mem [DEPTH];
  logic       in_range;

`ifdef INSTRUCTION_MEMORY_WRITE_EN
  logic write_block;

  // Release of rst is taken through one flop, so the first edge after release
  // never writes and the second one can.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) write_block <= 1'b1;
    else     write_block <= 1'b0;
  end

  // Reset reloads the whole image asynchronously and discards earlier writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= default_image(i);
      end
    end else if (bus.wr_en && !write_block) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end
`else
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign mem[g] = default_image(g);
  end

  logic unused_write_port;
  assign unused_write_port = ^{clk, rst, bus.wr_en, bus.wr_addr, bus.wr_data};
`endif

  // Fetching past the end of the store yields halt.
  assign in_range        = {1'b0, bus.index} < 33'(DEPTH);
  assign bus.instruction = in_range ? mem[bus.index[ADDR_W-1:0]] : OP_HALT;

  imm_assemble #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imm_assemble (
    .index    (bus.index),
    .mem      (mem),
    .constant (bus.constant)
  );

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed steps followed by
// random writes/reads checked against a byte-array reference model.
module tb_instruction_memory;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;

`ifdef INSTRUCTION_MEMORY_WRITE_EN
  localparam bit WRITES = 1'b1;
`else
  localparam bit WRITES = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instruction_memory_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_memory #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] model [DEPTH];
  int edges_since_release;

  function automatic logic [7:0] demo_byte(input int unsigned a);
    case (a)
      0:       return 8'h11;
      1:       return 8'hFE;
      2:       return 8'h20;
      3:       return 8'h10;
      4:       return 8'h01;
      8:       return 8'h30;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = demo_byte(i);
    edges_since_release = 0;
  endtask

  function automatic logic [31:0] exp_instr(input logic [31:0] idx);
    if (64'(idx) < 64'(DEPTH)) return 32'(model[idx[7:0]]);
    return 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] exp_const(input logic [31:0] idx);
    logic [31:0] r;
    logic [63:0] a;
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      a = 64'(idx) + 64'(k + 1);
      if (a < 64'(DEPTH)) r[8*k +: 8] = model[a[7:0]];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input string tag, input logic [31:0] idx);
    bus.index = idx;
    #1;
    check({tag, "/instr"}, 32'(bus.instruction), exp_instr(idx));
    check({tag, "/const"}, bus.constant, exp_const(idx));
  endtask

  // Drive one cycle from a negedge; the model accepts a write only from the
  // second rising edge after reset release onward.
  task automatic clock_step(input logic we, input logic [7:0] addr, input logic [7:0] data);
    bus.wr_en   = we;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(posedge clk);
    if (!rst) begin
      if (WRITES && we && edges_since_release >= 1) model[addr] = data;
      edges_since_release++;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] idx;
    rst         = 1'b1;
    bus.index   = 32'h0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = 8'h00;
    model_reset();
    #12;
    check_read("rst_idx0", 32'h0);
    check("rst_push0", 32'(bus.instruction), 32'h11);

    @(negedge clk);
    rst = 1'b0;
    check_read("idx3", 32'h3);
    check("push_imm", bus.constant, 32'h0000_0001);
    check("push_op", 32'(bus.instruction), 32'h10);
    check_read("idx8", 32'h8);
    check("br_op", 32'(bus.instruction), 32'h30);
    check_read("depth_m2", 32'(DEPTH - 2));
    check("depth_m2_hi", {8'h0, bus.constant[31:8]}, 32'h0);
    check_read("depth_m1", 32'(DEPTH - 1));
    check_read("depth", 32'(DEPTH));
    check("depth_halt", 32'(bus.instruction), 32'hFF);
    check_read("max_idx", 32'hFFFF_FFFF);
    check("max_const", bus.constant, 32'h0);
    check_read("max_m2", 32'hFFFF_FFFD);

    // first edge after release only clears the write block
    clock_step(1'b0, 8'h00, 8'h00);
    clock_step(1'b1, 8'h21, 8'h44);
    clock_step(1'b1, 8'h22, 8'h33);
    clock_step(1'b1, 8'h23, 8'h22);
    clock_step(1'b1, 8'h24, 8'h11);
    check_read("imm_le", 32'h20);
    check("imm_le_abs", bus.constant, WRITES ? 32'h1122_3344 : 32'h0);

    // read during write: old byte until the edge, new byte after
    bus.index   = 32'h4;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'h05;
    bus.wr_data = 8'hAB;
    #1;
    check("rdw_before", bus.constant, exp_const(32'h4));
    clock_step(1'b1, 8'h05, 8'hAB);
    check_read("rdw_after", 32'h4);
    check("rdw_byte", 32'(bus.constant[7:0]), WRITES ? 32'hAB : 32'h00);

    // overwrite opcode 0, then reset asynchronously mid-cycle
    clock_step(1'b1, 8'h00, 8'hFF);
    check_read("ovr_idx0", 32'h0);
    check("ovr_op", 32'(bus.instruction), WRITES ? 32'hFF : 32'h11);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    check_read("async_rst", 32'h0);
    check("async_rst_op", 32'(bus.instruction), 32'h11);
    check_read("async_rst_imm", 32'h20);
    @(negedge clk);
    rst = 1'b0;
    clock_step(1'b1, 8'h00, 8'h55);
    check_read("first_edge_ign", 32'h0);
    check("first_edge_op", 32'(bus.instruction), 32'h11);
    clock_step(1'b1, 8'h00, 8'h66);
    check_read("second_edge", 32'h0);
    check("second_edge_op", 32'(bus.instruction), WRITES ? 32'h66 : 32'h11);

    // random writes and reads across in-range, boundary and huge indexes
    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        check_read("rnd_rst", 32'($urandom_range(0, DEPTH - 1)));
        @(negedge clk);
        rst = 1'b0;
      end
      clock_step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      case ($urandom_range(0, 3))
        0:       idx = 32'($urandom_range(0, DEPTH - 1));
        1:       idx = 32'(DEPTH - 5) + 32'($urandom_range(0, 9));
        2:       idx = $urandom;
        default: idx = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
      endcase
      check_read("rnd", idx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
